// File: rtl/nv_nvdla_cvif_pkg.sv
// Shared CVIF constants: thread ids, CQ entry layout, AXI response codes.
package nv_nvdla_cvif_pkg;

   localparam int unsigned NUM_THREADS  = 5;
   localparam int unsigned B_FIFO_DEPTH = 2;
   localparam int unsigned ID_W         = 8;
   localparam int unsigned RESP_W       = 2;
   localparam int unsigned TID_W        = 3;

   localparam int unsigned BDMA = 0;
   localparam int unsigned SDP  = 1;
   localparam int unsigned PDP  = 2;
   localparam int unsigned CDP  = 3;
   localparam int unsigned RBK  = 4;

   // CQ entry: {axi_len[1:0], require_ack}
   localparam int unsigned CQ_ENTRY_W = 3;
   localparam int unsigned CQ_ACK_BIT = 0;
   localparam int unsigned CQ_LEN_LSB = 1;
   localparam int unsigned CQ_LEN_W   = 2;

   localparam logic [RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/nv_nvdla_cvif_write_eg_bfifo.sv
// Register FIFO with a registered not-full flag, used as the B-response skid buffer.
module nv_nvdla_cvif_write_eg_bfifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic             head_vld_c,
   output logic [WIDTH-1:0] head_data_c,
   output logic             not_full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_vld_c  = (count != '0);
   assign head_data_c = mem[rd_ptr];
   assign push_ok     = push & not_full;
   assign pop_ok      = pop & head_vld_c;

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // not_full is looked ahead from count_nxt so it is a clean flop output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         not_full <= 1'b0;
      end else begin
         count    <= count_nxt;
         not_full <= (count_nxt != CNT_W'(DEPTH));
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/nv_nvdla_cvif_write_eg.sv
// CVIF write egress: matches NOC B responses to CQ heads, issues completions and length credits.
module nv_nvdla_cvif_write_eg #(
   parameter int unsigned NUM_THREADS  = nv_nvdla_cvif_pkg::NUM_THREADS,
   parameter int unsigned B_FIFO_DEPTH = nv_nvdla_cvif_pkg::B_FIFO_DEPTH,
   parameter int unsigned ID_W         = nv_nvdla_cvif_pkg::ID_W
) (
   input  logic                                                nvdla_core_clk,
   input  logic                                                nvdla_core_rst,
   input  logic                                                noc2cvif_axi_b_bvalid,
   output logic                                                noc2cvif_axi_b_bready,
   input  logic [ID_W-1:0]                                     noc2cvif_axi_b_bid,
   input  logic [nv_nvdla_cvif_pkg::RESP_W-1:0]                noc2cvif_axi_b_bresp,
   input  logic [NUM_THREADS-1:0]                              cq_rd_pvld,
   output logic [NUM_THREADS-1:0]                              cq_rd_prdy,
   input  logic [NUM_THREADS*nv_nvdla_cvif_pkg::CQ_ENTRY_W-1:0] cq_rd_pd,
   output logic                                                cvif2bdma_wr_rsp_complete,
   output logic                                                cvif2sdp_wr_rsp_complete,
   output logic                                                cvif2pdp_wr_rsp_complete,
   output logic                                                cvif2cdp_wr_rsp_complete,
   output logic                                                cvif2rbk_wr_rsp_complete,
   output logic                                                eg2ig_axi_vld,
   output logic [nv_nvdla_cvif_pkg::CQ_LEN_W-1:0]              eg2ig_axi_len,
   output logic                                                eg_err_bid,
   output logic                                                eg_err_bresp
);

   import nv_nvdla_cvif_pkg::*;

   localparam int unsigned ENT_W = ID_W + RESP_W;

   logic                   fifo_not_full;
   logic                   b_push;
   logic                   head_vld;
   logic [ENT_W-1:0]       head_data;
   logic [ID_W-1:0]        head_bid;
   logic [RESP_W-1:0]      head_bresp;
   logic [TID_W-1:0]       head_tid;
   logic                   head_legal;
   logic [NUM_THREADS-1:0] tid_onehot;
   logic [CQ_ENTRY_W-1:0]  cur_entry;
   logic                   cur_pvld;
   logic                   retire;
   logic                   drop;
   logic                   fifo_pop;
   logic [NUM_THREADS-1:0] complete;

   assign noc2cvif_axi_b_bready = fifo_not_full;
   assign b_push                = noc2cvif_axi_b_bvalid & fifo_not_full;

   nv_nvdla_cvif_write_eg_bfifo #(
      .WIDTH (ENT_W),
      .DEPTH (B_FIFO_DEPTH)
   ) u_bfifo (
      .clk         (nvdla_core_clk),
      .rst         (nvdla_core_rst),
      .push        (b_push),
      .wr_data     ({noc2cvif_axi_b_bid, noc2cvif_axi_b_bresp}),
      .pop         (fifo_pop),
      .head_vld_c  (head_vld),
      .head_data_c (head_data),
      .not_full    (fifo_not_full)
   );

   assign head_bid   = head_data[ENT_W-1:RESP_W];
   assign head_bresp = head_data[RESP_W-1:0];
   assign head_tid   = head_bid[TID_W-1:0];
   assign head_legal = (head_bid[ID_W-1:TID_W] == '0) && (32'(head_tid) < NUM_THREADS);

   // Select the CQ head of the thread named by the B head
   always_comb begin
      tid_onehot = '0;
      cur_entry  = '0;
      cur_pvld   = 1'b0;
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
         if (32'(head_tid) == t) begin
            tid_onehot[t] = 1'b1;
            cur_entry     = cq_rd_pd[t*CQ_ENTRY_W +: CQ_ENTRY_W];
            cur_pvld      = cq_rd_pvld[t];
         end
      end
   end

   assign cq_rd_prdy = (head_vld && head_legal) ? tid_onehot : '0;
   assign retire     = head_vld & head_legal & cur_pvld;
   assign drop       = head_vld & ~head_legal;
   assign fifo_pop   = retire | drop;

   // Retire results appear one cycle later as single-cycle pulses
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         eg2ig_axi_vld <= 1'b0;
         eg2ig_axi_len <= '0;
         complete      <= '0;
         eg_err_bid    <= 1'b0;
         eg_err_bresp  <= 1'b0;
      end else begin
         eg2ig_axi_vld <= retire;
         eg2ig_axi_len <= retire ? cur_entry[CQ_LEN_LSB +: CQ_LEN_W] : '0;
         complete      <= (retire && cur_entry[CQ_ACK_BIT]) ? tid_onehot : '0;
         if (drop) eg_err_bid <= 1'b1;
         if (retire && (head_bresp != AXI_RESP_OKAY)) eg_err_bresp <= 1'b1;
      end
   end

   assign cvif2bdma_wr_rsp_complete = complete[BDMA];
   assign cvif2sdp_wr_rsp_complete  = complete[SDP];
   assign cvif2pdp_wr_rsp_complete  = complete[PDP];
   assign cvif2cdp_wr_rsp_complete  = complete[CDP];
   assign cvif2rbk_wr_rsp_complete  = complete[RBK];

endmodule
